// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit:
// op codes, sequencer states and default widths.
package mdu_defs;

    localparam int MDU_DATA_W = 32;
    localparam int DIV_STEPS  = MDU_DATA_W;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One shift/compare/subtract per step; next values exported.
module div_radix2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo_next,
    output logic [W-1:0] rem_next
);

    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W:0]   shifted;
    logic [W:0]   diff;
    logic         ge;

    // Remainder stays below the divisor, so W+1 bits hold the shifted value.
    assign shifted  = {rem_q, quo_q[W-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign ge       = ~diff[W];
    assign rem_next = ge ? diff[W-1:0] : shifted[W-1:0];
    assign quo_next = {quo_q[W-2:0], ge};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = rem_next;
            quo_d = quo_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer feeding HI/LO: stalls E while busy,
// cancels on flush, and pulses result_valid with the result.
module mdu_ctrl
    import mdu_defs::*;
#(
    parameter int DATA_W     = MDU_DATA_W,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] srca,
    input  logic [DATA_W-1:0] srcb,
    input  logic              flush,
    output logic              stall_mdu,
    output logic              result_valid,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int CNT_MAX = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mdu_op_e           op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              valid_q, valid_d;

    mdu_op_e           op_in;
    logic              sgn_in, sa_in, sb_in;
    logic              is_div_in, issue;
    logic [DATA_W-1:0] abs_a, abs_b;

    logic                mul_sgn;
    logic [2*DATA_W-1:0] ext_a, ext_b, product;

    logic [DATA_W-1:0] q_nx, r_nx;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    assign op_in     = mdu_op_e'(op);
    assign sgn_in    = op_is_signed(op_in);
    assign sa_in     = sgn_in & srca[DATA_W-1];
    assign sb_in     = sgn_in & srcb[DATA_W-1];
    assign is_div_in = (op_in == MDU_DIV) | (op_in == MDU_DIVU);
    assign issue     = (state_q == S_IDLE) & start & ~flush;
    assign abs_a     = sa_in ? -srca : srca;
    assign abs_b     = sb_in ? -srcb : srcb;

    // Sign-extending to 2*W makes one unsigned multiply serve both forms.
    assign mul_sgn = op_is_signed(op_q);
    assign ext_a   = {{DATA_W{mul_sgn & a_q[DATA_W-1]}}, a_q};
    assign ext_b   = {{DATA_W{mul_sgn & b_q[DATA_W-1]}}, b_q};
    assign product = ext_a * ext_b;

    div_radix2 #(
        .W(DATA_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (issue & is_div_in),
        .step     (state_q == S_DIV),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quo_next (q_nx),
        .rem_next (r_nx)
    );

    assign quo_fix = (sa_q ^ sb_q) ? -q_nx : q_nx;
    assign rem_fix = sa_q ? -r_nx : r_nx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d    = op_in;
                        a_d     = srca;
                        b_d     = srcb;
                        sa_d    = sa_in;
                        sb_d    = sb_in;
                        state_d = is_div_in ? S_DIV : S_MUL;
                        cnt_d   = is_div_in ? CNT_DIV : CNT_MUL;
                    end
                end
                S_MUL: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d      = S_DONE;
                        valid_d      = 1'b1;
                        {hi_d, lo_d} = product;
                    end
                end
                S_DIV: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
        end
    end

    assign stall_mdu    = (((state_q == S_IDLE) & start)
                          | (state_q == S_MUL)
                          | (state_q == S_DIV)) & ~flush;
    assign result_valid = valid_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table plus
// flush, reset and DONE-cycle sequences, with a result scoreboard.
module tb_mdu_ctrl;
    import mdu_defs::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        stall_mdu;
    logic        result_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    mdu_ctrl #(
        .DATA_W     (32),
        .MUL_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .srca         (srca),
        .srcb         (srcb),
        .flush        (flush),
        .stall_mdu    (stall_mdu),
        .result_valid (result_valid),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    logic [63:0] sb_q[$];
    int          total;
    int          passed;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    task automatic check(input logic [63:0] act, input logic [63:0] exp,
                         input string nm);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic sb_compare(input string nm);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check(1'b1, 1'b0, {nm, " scoreboard empty"});
        end else begin
            exp = sb_q.pop_front();
            check({hi_out, lo_out}, exp, {nm, " hi/lo"});
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi,
                          input logic [31:0] lo, input int lat,
                          input string nm);
        bit ok;
        bit seen;
        int cyc;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        sb_q.push_back({hi, lo});
        #1;
        check(stall_mdu, 1'b1, {nm, " stall@issue"});
        ok   = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1'b1;
                cyc  = k;
            end else if (!stall_mdu) begin
                ok = 1'b0;
            end
        end
        check(seen, 1'b1, {nm, " result seen"});
        check(64'(cyc), 64'(lat), {nm, " latency"});
        check(ok, 1'b1, {nm, " stall window"});
        check(stall_mdu, 1'b0, {nm, " stall@done"});
        sb_compare(nm);
        last_hi = hi;
        last_lo = lo;
        // start stays high through the DONE edge, as the held instruction would
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check(result_valid, 1'b0, {nm, " single pulse"});
        check(stall_mdu, 1'b0, {nm, " idle after"});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        total  = 0;
        passed = 0;
        vecs[0]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{MDU_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001};
        vecs[5]  = '{MDU_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[6]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{MDU_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[9]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        srca  = '0;
        srcb  = '0;
        flush = 1'b0;
        @(negedge clk);
        check(stall_mdu, 1'b0, "reset stall");
        check(result_valid, 1'b0, "reset valid");
        check(hi_out, 32'h0, "reset hi");
        check(lo_out, 32'h0, "reset lo");
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].op[1] ? 33 : 3, $sformatf("vec%0d", i));

        // flush in IDLE alongside start: nothing issues
        @(negedge clk);
        start = 1'b1;
        op    = MDU_MULT;
        srca  = 32'd9;
        srcb  = 32'd9;
        flush = 1'b1;
        #1;
        check(stall_mdu, 1'b0, "idle flush stall");
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        vcount = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (result_valid || stall_mdu) vcount++;
        end
        check(64'(vcount), 64'd0, "idle flush no issue");

        // DIVU killed at t+10, MULTU issued at t+11
        @(negedge clk);
        start = 1'b1;
        op    = MDU_DIVU;
        srca  = 32'd1000;
        srcb  = 32'd3;
        vcount = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (result_valid || !stall_mdu) vcount++;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        check(stall_mdu, 1'b0, "flush stall drop");
        check(64'(vcount), 64'd0, "flush pre window");
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check(result_valid, 1'b0, "flush no valid");
        check({hi_out, lo_out}, {last_hi, last_lo}, "flush hi/lo hold");
        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
               32'h00000001, 3, "post-flush multu");

        // flush during DONE: pulse still present
        @(negedge clk);
        start = 1'b1;
        op    = MDU_MULT;
        srca  = 32'd3;
        srcb  = 32'hFFFFFFFB;
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check(result_valid, 1'b1, "done flush valid");
        sb_compare("done flush");
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check(result_valid, 1'b0, "done flush single");

        // async reset mid-divide
        @(negedge clk);
        start = 1'b1;
        op    = MDU_DIV;
        srca  = 32'd100;
        srcb  = 32'd3;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check(stall_mdu, 1'b0, "rst mid stall");
        check(result_valid, 1'b0, "rst mid valid");
        check({hi_out, lo_out}, 64'h0, "rst mid hi/lo");
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (result_valid) vcount++;
        end
        check(64'(vcount), 64'd0, "rst no partial pulse");
        check(64'(sb_q.size()), 64'd0, "scoreboard drained");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
